// File: rtl/hs_req_sender.sv
// Source-side four-phase req/ack sender for the hand_shake CDC path.
// Holds data_out stable for the whole handshake; watchdog aborts stuck transfers.
module hs_req_sender #(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk_ff,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  req,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  ack_sync,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err,
  input  logic                  err_clr,
  output logic [CNT_WIDTH-1:0]  xfer_cnt
);

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ?
                        $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_MAX = (TIMEOUT_CYCLES > 0) ?
                        WD_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [WD_W-1:0] wd_cnt;
  logic            aborted;
  logic            wd_hit;
  logic            accept;
  logic            hi_exit;
  logic            hi_to;
  logic            lo_to;
  logic            finish;

  assign wd_hit   = WD_EN && (wd_cnt == WD_MAX);
  assign in_ready = (state == IDLE) & ~ack_sync;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk_ff) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid && in_ready) state_nx = WAIT_HI;
      WAIT_HI: if (ack_sync || wd_hit)   state_nx = WAIT_LO;
      WAIT_LO: if (!ack_sync)            state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ack beats a coincident watchdog hit in both wait states
  always_comb begin
    accept  = 1'b0;
    hi_exit = 1'b0;
    hi_to   = 1'b0;
    lo_to   = 1'b0;
    finish  = 1'b0;
    unique case (1'b1)
      state == IDLE: accept = in_valid & ~ack_sync;
      state == WAIT_HI: begin
        hi_exit = ack_sync | wd_hit;
        hi_to   = ~ack_sync & wd_hit;
      end
      state == WAIT_LO: begin
        finish = ~ack_sync;
        lo_to  = ack_sync & wd_hit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_ff) begin
    if (rst) begin
      req         <= 1'b0;
      data_out    <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      xfer_cnt    <= '0;
      wd_cnt      <= '0;
      aborted     <= 1'b0;
    end else begin
      done <= finish & ~aborted;
      if (accept) begin
        data_out <= in_data;
        req      <= 1'b1;
        aborted  <= 1'b0;
      end
      if (hi_exit) req <= 1'b0;
      if (hi_to) aborted <= 1'b1;
      if (finish && !aborted) xfer_cnt <= xfer_cnt + 1'b1;
      if (hi_to || lo_to) timeout_err <= 1'b1;
      else if (err_clr)   timeout_err <= 1'b0;
      // saturates at WD_MAX while parked in WAIT_LO
      if (state_nx != state)     wd_cnt <= '0;
      else if (busy && !wd_hit)  wd_cnt <= wd_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hs_req_sender.sv
// Directed bench for hs_req_sender: loopback ack with 2-cycle delay,
// or a manually driven ack for stale-ack, timeout and reset scenarios.
module tb_hs_req_sender;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       req;
  logic [7:0] data_out;
  logic       ack_sync;
  logic       busy;
  logic       done;
  logic       timeout_err;
  logic       err_clr;
  logic [1:0] xfer_cnt;

  logic loop_en;
  logic ack_man;
  logic d1, d2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!loop_en) begin
      d1 <= 1'b0;
      d2 <= 1'b0;
    end else begin
      d1 <= req;
      d2 <= d1;
    end
  end

  assign ack_sync = loop_en ? d2 : ack_man;

  hs_req_sender #(
    .DATA_WIDTH(8),
    .TIMEOUT_CYCLES(16),
    .CNT_WIDTH(2)
  ) dut (
    .clk_ff(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .req(req),
    .data_out(data_out),
    .ack_sync(ack_sync),
    .busy(busy),
    .done(done),
    .timeout_err(timeout_err),
    .err_clr(err_clr),
    .xfer_cnt(xfer_cnt)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; loop_en = 1'b0; ack_man = 1'b0;
    in_valid = 1'b0; err_clr = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; loop_en = 1'b0; ack_man = 1'b0;
    in_valid = 1'b0; err_clr = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", req); end
    n_chk++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", data_out); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_chk++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", timeout_err); end
    n_chk++; if (xfer_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", xfer_cnt); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int dn;
    int bad;
    do_reset();
    loop_en = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
    #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready0 got=%b exp=1", in_ready); end
    @(negedge clk);
    n_chk++; if (req !== 1'b1) begin n_fail++; $display("FAIL basic_req_rise got=%b exp=1", req); end
    n_chk++; if (data_out !== 8'hA5) begin n_fail++; $display("FAIL basic_data got=%h exp=a5", data_out); end
    in_valid = 1'b0;
    dn = 0; bad = 0;
    repeat (14) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
      if (data_out !== 8'hA5) bad++;
    end
    n_chk++; if (dn != 1) begin n_fail++; $display("FAIL basic_done_pulses got=%0d exp=1", dn); end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL basic_data_hold got=%0d exp=0 changes", bad); end
    n_chk++; if (xfer_cnt !== 2'd1) begin n_fail++; $display("FAIL basic_cnt got=%0d exp=1", xfer_cnt); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_end got=%b exp=1", in_ready); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [3];
    logic [7:0] pw;
    logic [7:0] prev_d;
    logic       prev_busy;
    logic       pend;
    int idx, dn, bad_stab, bad_acc, bad_ack;
    words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
    do_reset();
    loop_en = 1'b1; in_valid = 1'b1; in_data = words[0];
    idx = 0; dn = 0; bad_stab = 0; bad_acc = 0; bad_ack = 0;
    pend = 1'b0; pw = 8'h00; prev_busy = 1'b0; prev_d = data_out;
    for (int c = 0; c < 80 && !(idx == 3 && dn == 3); c++) begin
      @(negedge clk);
      if (pend) begin
        if (req !== 1'b1 || data_out !== pw) bad_acc++;
        idx++;
        pend = 1'b0;
        if (idx < 3) in_data = words[idx];
        else in_valid = 1'b0;
      end
      if (done === 1'b1) dn++;
      if (busy && prev_busy && data_out !== prev_d) bad_stab++;
      prev_busy = busy;
      prev_d = data_out;
      if (in_valid && in_ready) begin
        if (ack_sync !== 1'b0 || busy !== 1'b0) bad_ack++;
        pend = 1'b1;
        pw = in_data;
      end
    end
    n_chk++; if (idx != 3) begin n_fail++; $display("FAIL b2b_accepts got=%0d exp=3", idx); end
    n_chk++; if (dn != 3) begin n_fail++; $display("FAIL b2b_done_pulses got=%0d exp=3", dn); end
    n_chk++; if (xfer_cnt !== 2'd3) begin n_fail++; $display("FAIL b2b_cnt got=%0d exp=3", xfer_cnt); end
    n_chk++; if (bad_stab != 0) begin n_fail++; $display("FAIL b2b_data_stable got=%0d exp=0", bad_stab); end
    n_chk++; if (bad_acc != 0) begin n_fail++; $display("FAIL b2b_latch got=%0d exp=0", bad_acc); end
    n_chk++; if (bad_ack != 0) begin n_fail++; $display("FAIL b2b_ready_rule got=%0d exp=0", bad_ack); end
  endtask

  task automatic test_stale_ack();
    do_reset();
    ack_man = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
    #1;
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stale_ready got=%b exp=0", in_ready); end
    repeat (3) @(negedge clk);
    n_chk++; if (req !== 1'b0) begin n_fail++; $display("FAIL stale_req got=%b exp=0", req); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stale_busy got=%b exp=0", busy); end
    ack_man = 1'b0;
    #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stale_release_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    n_chk++; if (req !== 1'b1) begin n_fail++; $display("FAIL stale_accept_req got=%b exp=1", req); end
    n_chk++; if (data_out !== 8'h5A) begin n_fail++; $display("FAIL stale_accept_data got=%h exp=5a", data_out); end
    in_valid = 1'b0;
  endtask

  task automatic test_timeout_hi();
    int hi;
    int dn;
    do_reset();
    in_valid = 1'b1; in_data = 8'hC3;
    @(negedge clk);
    in_valid = 1'b0;
    hi = (req === 1'b1) ? 1 : 0;
    dn = 0;
    for (int c = 0; c < 40 && req === 1'b1; c++) begin
      @(negedge clk);
      if (req === 1'b1) hi++;
      if (done === 1'b1) dn++;
    end
    n_chk++; if (hi != 16) begin n_fail++; $display("FAIL to_hi_req_cycles got=%0d exp=16", hi); end
    n_chk++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_hi_err got=%b exp=1", timeout_err); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL to_hi_wait_lo got=%b exp=1", busy); end
    @(negedge clk);
    if (done === 1'b1) dn++;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL to_hi_idle got=%b exp=0", busy); end
    n_chk++; if (dn != 0) begin n_fail++; $display("FAIL to_hi_no_done got=%0d exp=0", dn); end
    n_chk++; if (xfer_cnt !== 2'd0) begin n_fail++; $display("FAIL to_hi_cnt got=%0d exp=0", xfer_cnt); end
    n_chk++; if (data_out !== 8'hC3) begin n_fail++; $display("FAIL to_hi_data got=%h exp=c3", data_out); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_chk++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_hi_clr got=%b exp=0", timeout_err); end
  endtask

  task automatic test_timeout_ack_race();
    do_reset();
    in_valid = 1'b1; in_data = 8'h99;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (15) @(negedge clk);
    n_chk++; if (req !== 1'b1) begin n_fail++; $display("FAIL race_req_last got=%b exp=1", req); end
    ack_man = 1'b1;
    @(negedge clk);
    n_chk++; if (req !== 1'b0) begin n_fail++; $display("FAIL race_req_drop got=%b exp=0", req); end
    n_chk++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL race_err got=%b exp=0", timeout_err); end
    ack_man = 1'b0;
    @(negedge clk);
    n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL race_done got=%b exp=1", done); end
    n_chk++; if (xfer_cnt !== 2'd1) begin n_fail++; $display("FAIL race_cnt got=%0d exp=1", xfer_cnt); end
    n_chk++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL race_err_end got=%b exp=0", timeout_err); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    do_reset();
    loop_en = 1'b1; in_valid = 1'b1; in_data = 8'h3C;
    @(negedge clk);
    in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    n_chk++; if (!seen || xfer_cnt !== 2'd1) begin n_fail++; $display("FAIL mid_pre_xfer got=%0d exp=1", xfer_cnt); end
    loop_en = 1'b0; ack_man = 1'b0;
    in_valid = 1'b1; in_data = 8'h77;
    @(negedge clk);
    in_valid = 1'b0; ack_man = 1'b1;
    @(negedge clk);
    n_chk++; if (req !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL mid_wait_lo got req=%b busy=%b exp req=0 busy=1", req, busy); end
    repeat (15) @(negedge clk);
    n_chk++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL mid_lo_early got=%b exp=0", timeout_err); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_chk++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL mid_lo_set_wins got=%b exp=1", timeout_err); end
    repeat (4) @(negedge clk);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_lo_stays got=%b exp=1", busy); end
    n_chk++; if (data_out !== 8'h77) begin n_fail++; $display("FAIL mid_lo_data got=%h exp=77", data_out); end
    rst = 1'b1;
    @(negedge clk);
    n_chk++; if (req !== 1'b0) begin n_fail++; $display("FAIL mid_rst_req got=%b exp=0", req); end
    n_chk++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL mid_rst_data got=%h exp=00", data_out); end
    n_chk++; if (xfer_cnt !== 2'd0) begin n_fail++; $display("FAIL mid_rst_cnt got=%0d exp=0", xfer_cnt); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
    n_chk++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_err got=%b exp=0", timeout_err); end
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready_ack got=%b exp=0", in_ready); end
    ack_man = 1'b0;
    #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready_free got=%b exp=1", in_ready); end
  endtask

  task automatic test_wrap();
    logic [1:0] exp_cnt [5];
    logic got;
    logic seen;
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3;
    exp_cnt[3] = 2'd0; exp_cnt[4] = 2'd1;
    do_reset();
    loop_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data = 8'h10 + 8'(k);
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
        if (in_ready === 1'b1) got = 1'b1;
        @(negedge clk);
      end
      in_valid = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        if (done === 1'b1) seen = 1'b1;
      end
      n_chk++;
      if (!got || !seen || xfer_cnt !== exp_cnt[k]) begin
        n_fail++;
        $display("FAIL wrap_cnt_%0d got=%0d exp=%0d accepted=%b done=%b", k, xfer_cnt, exp_cnt[k], got, seen);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stale_ack();
    test_timeout_hi();
    test_timeout_ack_race();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit reached got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/hs_req_sender.md
Name: hs_req_sender

Overview:
- Source-side four-phase request/acknowledge controller for the hand_shake CDC path.
- Captures a data word and drives a registered, glitch-free req toward the destination domain.
- Consumes ack_sync, which is the destination ack after it passes through the local dual_ff synchronizer in this clock domain.
- Provides a valid/ready front end, a completion pulse, a watchdog timeout and a transfer counter.

Parameters:
- DATA_WIDTH, 8, width of in_data and data_out
- TIMEOUT_CYCLES, 1024, max cycles in either wait state before the watchdog fires; 0 disables the watchdog
- CNT_WIDTH, 16, width of xfer_cnt

Ports:
- clk_ff  input  1  source-domain clock; all logic is on its rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream offers in_data
- in_data  input  DATA_WIDTH  word to transfer
- in_ready  output  1  block can accept a word this cycle
- req  output  1  registered request to the destination domain
- data_out  output  DATA_WIDTH  held data bus to the destination domain
- ack_sync  input  1  destination ack, already double-flopped into clk_ff
- busy  output  1  handshake in progress (state != IDLE)
- done  output  1  one-cycle pulse on successful completion
- timeout_err  output  1  sticky watchdog flag
- err_clr  input  1  clears timeout_err
- xfer_cnt  output  CNT_WIDTH  count of successful transfers, wraps

Behaviour:
- Interface: one clock, clk_ff; reset is synchronous and active-high, port rst.
- Reset values: state=IDLE, req=0, data_out=0, done=0, timeout_err=0, xfer_cnt=0, watchdog counter=0. rst has priority over all other inputs, including mid-handshake; req drops on the edge where rst is sampled.
- in_ready = (state==IDLE) & ~ack_sync. This is combinational from state and ack_sync. A new request never starts while a stale ack is high.

State machine:
- IDLE: on in_valid & in_ready, latch data_out<=in_data, req<=1, and go to WAIT_HI. req is visible the cycle after acceptance.
- WAIT_HI: when ack_sync=1, req<=0 and go to WAIT_LO.
- WAIT_LO: when ack_sync=0, go to IDLE.
  - If the transfer was not aborted: done=1 for that single cycle and xfer_cnt increments.
  - If it was aborted: no done pulse and no count.

Data stability:
- data_out changes only on acceptance in IDLE.
- It is held constant from req rise through the return to IDLE.

Watchdog:
- The counter resets on every state change and increments each cycle in WAIT_HI or WAIT_LO.
- WAIT_HI timeout: when the count reaches TIMEOUT_CYCLES-1 with ack_sync still 0, set req<=0, set timeout_err<=1 and the aborted flag, and go to WAIT_LO.
- WAIT_LO timeout: set timeout_err<=1 and stay in WAIT_LO. The counter saturates. The block only leaves WAIT_LO when ack_sync=0.
- TIMEOUT_CYCLES=0 disables the watchdog entirely.
- Timeout vs. ack in the same cycle: ack wins, and no error is flagged.
- err_clr clears timeout_err. If err_clr and a new timeout occur in the same cycle, the set wins.

Other rules:
- xfer_cnt wraps from 2^CNT_WIDTH-1 to 0.
- busy = (state != IDLE).
- in_valid while busy is ignored; upstream must hold in_valid until in_ready.

Test Plan:
- Basic transfer: rst 2 cycles, then in_valid=1 and in_data=0xA5 with ack looped back through a 2-cycle delay -> req rises 1 cycle after accept and data_out=0xA5 throughout; done pulses once; xfer_cnt=1; in_ready returns high.
- Back-to-back: 0x01, 0x02, 0x03 offered continuously -> each accepted only when IDLE and ack_sync=0; data_out never changes while req=1; xfer_cnt=3; exactly 3 done pulses.
- Stale ack: hold ack_sync=1 in IDLE with in_valid=1 -> in_ready=0 and req stays 0; release ack -> accepted next cycle.
- Timeout in WAIT_HI: TIMEOUT_CYCLES=16, ack never rises -> req drops after 16 cycles in WAIT_HI; timeout_err=1; no done; xfer_cnt unchanged; block returns to IDLE; err_clr -> timeout_err=0.
- Reset mid-operation: assert rst while in WAIT_LO with ack_sync=1 -> next edge req=0, data_out=0, xfer_cnt=0, busy=0; in_ready stays 0 until ack_sync=0.
- Counter wrap: CNT_WIDTH=2, 5 transfers -> xfer_cnt sequence 1, 2, 3, 0, 1.
